// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave pipelined Wishbone arbiter with outstanding-transaction limit.
// Ports: clk/rst_n (async active-low); m0_*/m1_* master-side Wishbone (cyc, stb, we, adr, sel,
// dat_o in; stall, ack, err, dat_i out); s_* slave-side Wishbone (cyc, stb, we, adr, sel, dat_o out;
// stall, ack, err, dat_i in). m0 wins the first tie after reset; grants last a whole CYC span.
module wb_arbiter2 #(
    parameter int PENDING = 16,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_dat_o,
    output logic            m0_stall,
    output logic            m0_ack,
    output logic            m0_err,
    output logic [DW-1:0]   m0_dat_i,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_dat_o,
    output logic            m1_stall,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [DW-1:0]   m1_dat_i,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_stall,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic [DW-1:0]   s_dat_i
);
    localparam int CW = $clog2(PENDING) + 1;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;
    owner_t          owner_q;
    logic            last_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            own0, own1, full, accept, done;
    assign own0   = (owner_q == OWN0);
    assign own1   = (owner_q == OWN1);
    assign full   = (cnt_q == CW'(PENDING));
    assign s_cyc  = own0 ? m0_cyc : (own1 & m1_cyc);
    assign s_stb  = ~full & (own0 ? m0_stb : (own1 & m1_stb));
    assign s_we   = own1 ? m1_we    : m0_we;
    assign s_adr  = own1 ? m1_adr   : m0_adr;
    assign s_sel  = own1 ? m1_sel   : m0_sel;
    assign s_dat_o = own1 ? m1_dat_o : m0_dat_o;
    assign m0_stall = ~own0 | s_stall | full;
    assign m1_stall = ~own1 | s_stall | full;
    assign m0_ack = own0 & s_ack & s_cyc;
    assign m1_ack = own1 & s_ack & s_cyc;
    assign m0_err = own0 & s_err & s_cyc;
    assign m1_err = own1 & s_err & s_cyc;
    assign m0_dat_i = s_dat_i;
    assign m1_dat_i = s_dat_i;
    assign accept = s_stb & ~s_stall;
    assign done   = s_ack | s_err;
    // Dropping CYC abandons any responses still in flight, so the count restarts from zero.
    assign cnt_d = !s_cyc ? '0 :
                   (accept && !done) ? cnt_q + 1'b1 :
                   (done && !accept && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (owner_q)
                // On a tie the master that was not granted last wins.
                IDLE: if (m0_cyc && (!m1_cyc || last_q)) owner_q <= OWN0;
                      else if (m1_cyc) owner_q <= OWN1;
                OWN0: if (!m0_cyc) begin
                          last_q  <= 1'b0;
                          owner_q <= m1_cyc ? OWN1 : IDLE;
                      end
                OWN1: if (!m1_cyc) begin
                          last_q  <= 1'b1;
                          owner_q <= m0_cyc ? OWN0 : IDLE;
                      end
                default: owner_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave pipelined Wishbone arbiter.
- Sits directly downstream of the core-to-Wishbone converters: instruction-side bridge on m0, data-side bridge on m1, single slave (bus/interconnect) on s.
- Grants the bus for a whole cycle (CYC high span), enforces an outstanding-transaction limit, and routes ACK/ERR back to the owning master only.

Parameters:
- PENDING, 16, max outstanding slave transactions (accepted but not yet ACK/ERR).
- AW, 32, address width.
- DW, 32, data width; SEL width = DW/8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m1_cyc  in  1  master cycle.
- m0_stb, m1_stb  in  1  master strobe.
- m0_we, m1_we  in  1  write enable.
- m0_adr, m1_adr  in  AW  address.
- m0_sel, m1_sel  in  DW/8  byte select.
- m0_dat_o, m1_dat_o  in  DW  master write data.
- m0_stall, m1_stall  out  1  stall to master.
- m0_ack, m1_ack  out  1  ack to master.
- m0_err, m1_err  out  1  error to master.
- m0_dat_i, m1_dat_i  out  DW  read data to master.
- s_cyc, s_stb, s_we  out  1  slave cycle, strobe, write enable.
- s_adr  out  AW  slave address.
- s_sel  out  DW/8  slave byte select.
- s_dat_o  out  DW  slave write data.
- s_stall, s_ack, s_err  in  1  slave stall, ack, error.
- s_dat_i  in  DW  slave read data.

Behaviour:
- State register owner ∈ {IDLE, OWN0, OWN1}; last_grant register (0/1); outstanding counter cnt, width $clog2(PENDING)+1, unsigned.
- Reset (async, any time, mid-transfer included): owner=IDLE, last_grant=1 (so m0 wins the first tie), cnt=0. Outputs s_cyc=s_stb=0; m0_stall=m1_stall=1; all ack/err=0.
- IDLE:
  - s_cyc=0, s_stb=0; both masters stalled, ack/err=0.
  - Next state: only m0_cyc → OWN0; only m1_cyc → OWN1; both → the master != last_grant.
  - Arbitration latency is 1 cycle: a master raising CYC in IDLE sees stall=1 that cycle and can be accepted no earlier than the next cycle.
- OWNx:
  - s_cyc=mx_cyc; s_stb=mx_stb & ~full, where full=(cnt==PENDING).
  - s_we, s_adr, s_sel, s_dat_o = owner's signals; mx_stall=s_stall|full.
  - mx_ack=s_ack & s_cyc; mx_err=s_err & s_cyc.
  - Non-owner: stall=1, ack=0, err=0.
  - m0_dat_i=m1_dat_i=s_dat_i (broadcast; only the owner's ack qualifies it).
  - Non-owner address/data are don't-care for the slave.
- Counter:
  - accept=s_stb&~s_stall; done=s_ack|s_err.
  - accept&~done → cnt+1; done&~accept → cnt-1; both or neither → hold.
  - done with cnt==0 is ignored (no underflow).
  - s_cyc==0 → cnt cleared to 0 next cycle (owner abort discards outstanding responses).
- Release: in OWNx, when mx_cyc==0:
  - last_grant←x.
  - Next state = OWN(other) if other's cyc=1, else IDLE.
  - The switch is registered, so there is no cycle where the new owner drives the slave in the same cycle the old one drops CYC.
  - The other master therefore waits at least 1 cycle after the owner deasserts CYC.
- Ownership never changes while the owner holds CYC, regardless of the other master (no preemption).
- Full: at cnt==PENDING, s_stb is forced 0 and the owner is stalled; an ack in the same cycle frees one slot, taking effect the following cycle.

Test Plan:
- Reset then m0 single read (adr=0x100, s_stall=0, ack 1 cycle after accept, s_dat_i=0xDEADBEEF) → m0 granted 1 cycle after CYC; m0_ack=1 with m0_dat_i=0xDEADBEEF; m1_ack stays 0; cnt returns to 0.
- m0_cyc and m1_cyc rise in the same cycle after reset → OWN0 first. When m0 drops CYC → OWN1. Next simultaneous request from IDLE → m1 is not preferred (m0 wins, since last_grant=1).
- m1 issues 4 pipelined writes back-to-back (sel=0xF, data 1..4) while m0 requests → all 4 reach the slave in order; m0_stall=1 throughout; m0 granted 1 cycle after m1_cyc falls.
- PENDING=2, slave withholds ack, m0 streams 3 reads → 2 accepted then m0_stall=1 and s_stb=0. First ack → third accepted the next cycle; cnt never exceeds 2.
- s_err=1 on an m1 transaction → m1_err=1, m0_err=0, and cnt decrements.
- Assert rst_n=0 with cnt=3 in OWN1 → immediately s_cyc=0 and both stalls=1. After release: IDLE, cnt=0.
